// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg: OPMODE field positions and X/Z mux encodings shared by the MAC slice
package dsp_mac_pkg;
    localparam int OP_X       = 0;
    localparam int OP_Z       = 2;
    localparam int OP_PRE     = 4;
    localparam int OP_CIN     = 5;
    localparam int OP_PRESUB  = 6;
    localparam int OP_POSTSUB = 7;
    typedef enum logic [1:0] {X_ZERO, X_M, X_P, X_DAB} xsel_e;
    typedef enum logic [1:0] {Z_ZERO, Z_PCIN, Z_P, Z_C} zsel_e;
endpackage

// File: rtl/dsp_mac_slice_if.sv
// dsp_mac_slice_if: operand, control and result bundle of the MAC slice
interface dsp_mac_slice_if #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = 48
);
    logic                       ce;
    logic [A_WIDTH-1:0]         a;
    logic [B_WIDTH-1:0]         b;
    logic [B_WIDTH-1:0]         bcin;
    logic [B_WIDTH-1:0]         d;
    logic [P_WIDTH-1:0]         c;
    logic [P_WIDTH-1:0]         pcin;
    logic                       carryin;
    logic [7:0]                 opmode;
    logic                       in_valid;
    logic                       in_last;
    logic [A_WIDTH+B_WIDTH-1:0] m;
    logic [P_WIDTH-1:0]         p;
    logic [P_WIDTH-1:0]         pcout;
    logic [B_WIDTH-1:0]         bcout;
    logic                       carryout;
    logic                       carryoutf;
    logic                       out_valid;
    logic                       out_last;
    logic                       overflow;
    logic                       patterndetect;
    modport master (
        output ce, a, b, bcin, d, c, pcin, carryin, opmode, in_valid, in_last,
        input  m, p, pcout, bcout, carryout, carryoutf, out_valid, out_last, overflow, patterndetect
    );
    modport slave (
        input  ce, a, b, bcin, d, c, pcin, carryin, opmode, in_valid, in_last,
        output m, p, pcout, bcout, carryout, carryoutf, out_valid, out_last, overflow, patterndetect
    );
endinterface

// File: rtl/dsp_delay_line.sv
// dsp_delay_line: N-stage register chain with clock enable and async reset; N=0 is a wire
module dsp_delay_line #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (N == 0) begin : g_wire
        assign q = d;
    end else begin : g_regs
        logic [W-1:0] r [N];
        // shift the chain only when enabled so a stall freezes every stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N; i++) r[i] <= '0;
            end else if (ce) begin
                r[0] <= d;
                for (int i = 1; i < N; i++) r[i] <= r[i-1];
            end
        end
        assign q = r[N-1];
    end
endmodule

// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: pre-adder, signed multiplier and post-adder/accumulator with frame handling
module dsp_mac_slice
    import dsp_mac_pkg::*;
#(
    parameter int                 A_WIDTH    = 18,
    parameter int                 B_WIDTH    = 18,
    parameter int                 P_WIDTH    = 48,
    parameter int                 IN_REGS    = 1,
    parameter int                 MREG       = 1,
    parameter string              B_INPUT    = "DIRECT",
    parameter string              CARRYINSEL = "OPMODE5",
    parameter int                 SATURATE   = 0,
    parameter logic [P_WIDTH-1:0] PATTERN    = '0,
    parameter logic [P_WIDTH-1:0] MASK       = '1
) (
    input logic            clk,
    input logic            rst,
    dsp_mac_slice_if.slave bus
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH;
    localparam int S_WIDTH = A_WIDTH + 2 * B_WIDTH + P_WIDTH + 11;
    localparam bit CASC    = B_INPUT == "CASCADE";
    localparam bit CIN_OP  = CARRYINSEL == "OPMODE5";
    localparam bit SAT     = SATURATE != 0;

    logic [A_WIDTH-1:0] a1, a2;
    logic [B_WIDTH-1:0] b1, b2, d1, d2, bb;
    logic [P_WIDTH-1:0] c1, c2;
    logic [7:0]         op1, op2;
    logic               ci1, ci2, v1, v2, l1, l2;
    logic [M_WIDTH-1:0] mc, m2;
    logic [P_WIDTH-1:0] x, z, pn, p;
    logic [P_WIDTH:0]   sum, sw;
    logic               cin, ovf, pd, first, co, ovr, pdr, ov_valid, ov_last;
    xsel_e              xs;
    zsel_e              zs;

    dsp_delay_line #(.W(S_WIDTH), .N(IN_REGS)) u_in (
        .clk(clk), .rst(rst), .ce(bus.ce),
        .d({bus.a, CASC ? bus.bcin : bus.b, bus.d, bus.c, bus.opmode, bus.carryin, bus.in_valid, bus.in_last}),
        .q({a1, b1, d1, c1, op1, ci1, v1, l1})
    );

    // pre-adder wraps at B_WIDTH, then a full-width signed multiply
    always_comb begin
        bb = op1[OP_PRE] ? (op1[OP_PRESUB] ? d1 - b1 : d1 + b1) : b1;
        mc = $signed({{B_WIDTH{a1[A_WIDTH-1]}}, a1}) * $signed({{A_WIDTH{bb[B_WIDTH-1]}}, bb});
    end

    dsp_delay_line #(.W(M_WIDTH + S_WIDTH), .N(MREG)) u_m (
        .clk(clk), .rst(rst), .ce(bus.ce),
        .d({mc, a1, b1, d1, c1, op1, ci1, v1, l1}),
        .q({m2, a2, b2, d2, c2, op2, ci2, v2, l2})
    );

    // post-adder: unsigned P_WIDTH+1 sum for carry/borrow, sign-extended copy for overflow
    always_comb begin
        xs  = xsel_e'(op2[OP_X +: 2]);
        zs  = zsel_e'(op2[OP_Z +: 2]);
        x   = xs == X_M   ? {{(P_WIDTH-M_WIDTH){m2[M_WIDTH-1]}}, m2} :
              xs == X_P   ? (first ? '0 : p) :
              xs == X_DAB ? P_WIDTH'({d2, a2, b2}) : '0;
        z   = zs == Z_PCIN ? bus.pcin :
              zs == Z_P    ? (first ? '0 : p) :
              zs == Z_C    ? c2 : '0;
        cin = CIN_OP ? op2[OP_CIN] : ci2;
        sum = op2[OP_POSTSUB] ? {1'b0, z} - {1'b0, x} - {{P_WIDTH{1'b0}}, cin}
                              : {1'b0, z} + {1'b0, x} + {{P_WIDTH{1'b0}}, cin};
        sw  = op2[OP_POSTSUB] ? {z[P_WIDTH-1], z} - {x[P_WIDTH-1], x} - {{P_WIDTH{1'b0}}, cin}
                              : {z[P_WIDTH-1], z} + {x[P_WIDTH-1], x} + {{P_WIDTH{1'b0}}, cin};
        ovf = SAT && (sw[P_WIDTH] ^ sw[P_WIDTH-1]);
        pn  = ovf ? (sw[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}})
                  : sum[P_WIDTH-1:0];
        pd  = ((pn ^ PATTERN) & ~MASK) == '0;
    end

    // P stage: results move only on enabled valid beats; LAST re-arms the frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p        <= '0;
            co       <= 1'b0;
            ovr      <= 1'b0;
            pdr      <= 1'b0;
            ov_valid <= 1'b0;
            ov_last  <= 1'b0;
            first    <= 1'b1;
        end else if (bus.ce) begin
            ov_valid <= v2;
            ov_last  <= v2 & l2;
            if (v2) begin
                p     <= pn;
                co    <= sum[P_WIDTH];
                ovr   <= ovf;
                pdr   <= pd;
                first <= l2;
            end
        end
    end

    assign bus.m             = m2;
    assign bus.bcout         = b1;
    assign bus.p             = p;
    assign bus.pcout         = p;
    assign bus.carryout      = co;
    assign bus.carryoutf     = co;
    assign bus.overflow      = ovr;
    assign bus.patterndetect = pdr;
    assign bus.out_valid     = ov_valid;
    assign bus.out_last      = ov_last;
endmodule

// File: tb/tb_dsp_mac_slice.sv
// tb_dsp_mac_slice: directed vectors with a queue scoreboard checked by an output monitor
module tb_dsp_mac_slice;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;

    typedef struct packed {
        logic [PW-1:0]    p;
        logic [AW+BW-1:0] m;
        logic             co;
        logic             ov;
        logic             pd;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce_seen = 1'b0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dsp_mac_slice_if #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) bus ();

    dsp_mac_slice #(
        .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .IN_REGS(1), .MREG(1),
        .SATURATE(1), .PATTERN(48'h18), .MASK(48'hFFFF_FFFF_FF00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    function automatic exp_t ex(input logic [PW-1:0] p, input logic [AW+BW-1:0] m,
                                input logic co, input logic ov, input logic pd, input logic last);
        return {p, m, co, ov, pd, last};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] d, input logic [PW-1:0] c, input logic last,
                        input exp_t e, input int gap);
        bus.opmode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.d        = d;
        bus.c        = c;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (gap) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_pending", 64'(sb.size()), 64'd0);
        repeat (2) step();
    endtask

    always @(posedge clk) ce_seen <= bus.ce;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ce_seen && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got p=%0h expected no output", bus.p);
            end else begin
                e = sb.pop_front();
                chk("p", 64'(bus.p), 64'(e.p));
                chk("m", 64'(bus.m), 64'(e.m));
                chk("carryout", 64'(bus.carryout), 64'(e.co));
                chk("overflow", 64'(bus.overflow), 64'(e.ov));
                chk("patterndetect", 64'(bus.patterndetect), 64'(e.pd));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    initial begin
        bus.ce = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.bcin = '0;
        bus.d = '0;
        bus.c = '0;
        bus.pcin = '0;
        bus.carryin = 1'b0;
        bus.opmode = '0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        #2 rst = 1'b1;
        repeat (2) step();
        chk("reset_p", 64'(bus.p), 64'd0);
        chk("reset_m", 64'(bus.m), 64'd0);
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_last", 64'(bus.out_last), 64'd0);
        chk("reset_carryout", 64'(bus.carryout), 64'd0);
        chk("reset_bcout", 64'(bus.bcout), 64'd0);
        chk("reset_pd", 64'(bus.patterndetect), 64'd0);
        rst = 1'b0;
        step();

        send(8'h10, 2, 3, 1, 0, 1'b1, ex(48'h0, 8, 0, 0, 0, 1), 3);
        send(8'h50, 2, 3, 5, 0, 1'b1, ex(48'h0, 4, 0, 0, 0, 1), 3);
        send(8'h3D, 2, 3, 2, 48'h1, 1'b1, ex(48'hC, 10, 0, 0, 0, 1), 3);
        send(8'hBD, 2, 3, 2, 48'hF, 1'b1, ex(48'h4, 10, 0, 0, 0, 1), 3);
        send(8'h8D, 2, 3, 0, 48'h1, 1'b1, ex(48'hFFFF_FFFF_FFFB, 6, 1, 0, 0, 1), 3);
        send(8'h03, 2, 3, 1, 0, 1'b1, ex(48'h0010_0008_0003, 6, 0, 0, 0, 1), 3);
        send(8'h0D, 1, 1, 0, 48'h7FFF_FFFF_FFFF, 1'b1, ex(48'h7FFF_FFFF_FFFF, 1, 0, 1, 0, 1), 3);
        drain();

        send(8'h09, 2, 3, 0, 0, 1'b0, ex(48'h06, 6, 0, 0, 0, 0), 0);
        send(8'h09, 2, 3, 0, 0, 1'b0, ex(48'h0C, 6, 0, 0, 0, 0), 0);
        send(8'h09, 2, 3, 0, 0, 1'b0, ex(48'h12, 6, 0, 0, 0, 0), 0);
        send(8'h09, 2, 3, 0, 0, 1'b1, ex(48'h18, 6, 0, 0, 1, 1), 0);
        send(8'h09, 2, 3, 0, 0, 1'b1, ex(48'h06, 6, 0, 0, 0, 1), 3);
        drain();

        bus.opmode = 8'h09;
        bus.a = 2;
        bus.b = 3;
        bus.in_valid = 1'b1;
        bus.in_last = 1'b0;
        sb.push_back(ex(48'h06, 6, 0, 0, 0, 0));
        step();
        sb.push_back(ex(48'h0C, 6, 0, 0, 0, 0));
        step();
        sb.push_back(ex(48'h12, 6, 0, 0, 0, 0));
        step();
        bus.in_last = 1'b1;
        sb.push_back(ex(48'h18, 6, 0, 0, 1, 1));
        bus.ce = 1'b0;
        repeat (3) begin
            step();
            chk("stall_p", 64'(bus.p), 64'h6);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.ce = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        drain();

        send(8'h09, 2, 3, 0, 0, 1'b0, ex(48'h06, 6, 0, 0, 0, 0), 3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_p", 64'(bus.p), 64'd0);
        chk("rst_m", 64'(bus.m), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_bcout", 64'(bus.bcout), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        send(8'h09, 2, 3, 0, 0, 1'b1, ex(48'h06, 6, 0, 0, 0, 1), 3);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
